// File: rtl/board_state.sv
// Authoritative 8x8 chessboard and side-to-move. Turns the pick/place level from
// the cursor stage into committed moves, with capture, promotion and turn pulses.
module board_state #(
  parameter logic [2:0] PROMO_TYPE  = 3'd5,
  parameter logic       WHITE_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        new_game,
  input  logic [5:0]  mouse_position,
  input  logic        pick_place,
  input  logic [63:0] possible_moves,
  output logic [3:0]  board [0:7][0:7],
  output logic        white_turn,
  output logic        begin_turn,
  output logic        move_done,
  output logic        move_reject,
  output logic [5:0]  last_src,
  output logic [5:0]  last_dst,
  output logic [3:0]  captured,
  output logic        game_over
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HELD   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        pp_q, pp_d;
  logic [5:0]  src_q, src_d;
  logic [5:0]  dst_q, dst_d;
  logic        mask_q, mask_d;
  logic        turn_q, turn_d;
  logic        go_q, go_d;
  logic [5:0]  last_src_q, last_src_d;
  logic [5:0]  last_dst_q, last_dst_d;
  logic [3:0]  capt_q, capt_d;
  logic        begin_q, begin_d;
  logic        reject_q, reject_d;
  logic [3:0]  board_q [0:7][0:7];
  logic [3:0]  board_d [0:7][0:7];

  logic        rise, fall;
  logic [3:0]  pick_piece, src_piece, dst_piece, moved_piece;

  // Standard opening position: black on rows 0-1, white on rows 6-7.
  function automatic logic [3:0] init_piece(input logic [2:0] row, input logic [2:0] col);
    logic [2:0] back;
    case (col)
      3'd0, 3'd7: back = 3'd4;
      3'd1, 3'd6: back = 3'd2;
      3'd2, 3'd5: back = 3'd3;
      3'd3:       back = 3'd5;
      default:    back = 3'd6;
    endcase
    case (row)
      3'd0:    init_piece = {1'b1, back};
      3'd1:    init_piece = 4'h9;
      3'd6:    init_piece = 4'h1;
      3'd7:    init_piece = {1'b0, back};
      default: init_piece = 4'h0;
    endcase
  endfunction

  assign rise = pick_place & ~pp_q;
  assign fall = ~pick_place & pp_q;

  // pp_q keeps tracking the input through new_game so a still-held button
  // does not look like a fresh pick once the board is re-initialised.
  assign pp_d = pick_place;

  // Next-state, board update and pulse generation.
  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    dst_d      = dst_q;
    mask_d     = mask_q;
    turn_d     = turn_q;
    go_d       = go_q;
    last_src_d = last_src_q;
    last_dst_d = last_dst_q;
    capt_d     = capt_q;
    begin_d    = 1'b0;
    reject_d   = 1'b0;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        board_d[r][c] = board_q[r][c];
      end
    end

    pick_piece = board_q[mouse_position[5:3]][mouse_position[2:0]];
    src_piece  = board_q[src_q[5:3]][src_q[2:0]];
    dst_piece  = board_q[dst_q[5:3]][dst_q[2:0]];
    if (src_piece[2:0] == 3'd1 &&
        ((!src_piece[3] && dst_q[5:3] == 3'd0) || (src_piece[3] && dst_q[5:3] == 3'd7))) begin
      moved_piece = {src_piece[3], PROMO_TYPE};
    end else begin
      moved_piece = src_piece;
    end

    if (rst || new_game) begin
      state_d    = IDLE;
      src_d      = 6'd0;
      dst_d      = 6'd0;
      mask_d     = 1'b0;
      turn_d     = WHITE_FIRST;
      go_d       = 1'b0;
      last_src_d = 6'd0;
      last_dst_d = 6'd0;
      capt_d     = 4'd0;
      for (int r = 0; r < 8; r++) begin
        for (int c = 0; c < 8; c++) begin
          board_d[r][c] = init_piece(3'(r), 3'(c));
        end
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (rise && !go_q) begin
            src_d = mouse_position;
            // Colour bit 0 is white, so the piece must have colour == ~white_turn.
            if (pick_piece != 4'h0 && pick_piece[3] == ~turn_q) begin
              state_d = HELD;
            end else begin
              reject_d = 1'b1;
            end
          end else begin
            state_d = IDLE;
          end
        end
        HELD: begin
          if (fall) begin
            dst_d   = mouse_position;
            mask_d  = possible_moves[mouse_position];
            state_d = COMMIT;
          end else begin
            state_d = HELD;
          end
        end
        COMMIT: begin
          state_d = IDLE;
          if (dst_q == src_q) begin
            state_d = IDLE;
          end else if (!mask_q) begin
            reject_d = 1'b1;
          end else begin
            board_d[dst_q[5:3]][dst_q[2:0]] = moved_piece;
            board_d[src_q[5:3]][src_q[2:0]] = 4'h0;
            capt_d     = dst_piece;
            last_src_d = src_q;
            last_dst_d = dst_q;
            turn_d     = ~turn_q;
            begin_d    = 1'b1;
            if (dst_piece[2:0] == 3'd6) begin
              go_d = 1'b1;
            end else begin
              go_d = go_q;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and board registers; reset is folded into the _d logic.
  always_ff @(posedge clk) begin
    state_q    <= state_d;
    pp_q       <= pp_d;
    src_q      <= src_d;
    dst_q      <= dst_d;
    mask_q     <= mask_d;
    turn_q     <= turn_d;
    go_q       <= go_d;
    last_src_q <= last_src_d;
    last_dst_q <= last_dst_d;
    capt_q     <= capt_d;
    begin_q    <= begin_d;
    reject_q   <= reject_d;
    board_q    <= board_d;
  end

  assign board       = board_q;
  assign white_turn  = turn_q;
  assign begin_turn  = begin_q;
  assign move_done   = begin_q;
  assign move_reject = reject_q;
  assign last_src    = last_src_q;
  assign last_dst    = last_dst_q;
  assign captured    = capt_q;
  assign game_over   = go_q;

endmodule

// File: tb/tb_board_state.sv
// Self-checking bench for board_state: directed chess scenarios plus random
// pick/drop traffic compared against a move-level board model.
module tb_board_state;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        new_game = 1'b0;
  logic [5:0]  mouse_position = 6'd0;
  logic        pick_place = 1'b0;
  logic [63:0] possible_moves = 64'd0;
  logic [3:0]  board [0:7][0:7];
  logic        white_turn, begin_turn, move_done, move_reject, game_over;
  logic [5:0]  last_src, last_dst;
  logic [3:0]  captured;

  int errors = 0;
  int checks = 0;

  board_state dut (
    .clk(clk), .rst(rst), .new_game(new_game), .mouse_position(mouse_position),
    .pick_place(pick_place), .possible_moves(possible_moves), .board(board),
    .white_turn(white_turn), .begin_turn(begin_turn), .move_done(move_done),
    .move_reject(move_reject), .last_src(last_src), .last_dst(last_dst),
    .captured(captured), .game_over(game_over)
  );

  always #5 clk = ~clk;

  // Reference model: game state tracked per pick/drop action.
  logic [3:0] mb [0:7][0:7];
  logic       m_turn, m_go, m_held, pp_prev;
  logic [5:0] m_src, m_lsrc, m_ldst;
  logic [3:0] m_capt;
  int exp_bt = 0, exp_rej = 0, bt_cnt = 0, rej_cnt = 0;
  logic check_en = 1'b0;
  logic live = 1'b0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_init();
    logic [2:0] back [8];
    back = '{3'd4, 3'd2, 3'd3, 3'd5, 3'd6, 3'd3, 3'd2, 3'd4};
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        mb[r][c] = 4'h0;
    for (int c = 0; c < 8; c++) begin
      mb[0][c] = {1'b1, back[c]};
      mb[1][c] = 4'h9;
      mb[6][c] = 4'h1;
      mb[7][c] = {1'b0, back[c]};
    end
    m_turn = 1'b1; m_go = 1'b0; m_held = 1'b0;
    m_src = 6'd0; m_lsrc = 6'd0; m_ldst = 6'd0; m_capt = 4'd0;
  endtask

  task automatic model_pick(input logic [5:0] sq);
    logic [3:0] p;
    p = mb[sq[5:3]][sq[2:0]];
    if (!m_go) begin
      if (p != 4'h0 && p[3] == !m_turn) begin
        m_held = 1'b1;
        m_src  = sq;
      end else begin
        exp_rej++;
      end
    end
  endtask

  task automatic model_drop(input logic [5:0] sq, input logic [63:0] mask);
    logic [3:0] p;
    if (m_held) begin
      m_held = 1'b0;
      if (sq != m_src) begin
        if (!mask[sq]) begin
          exp_rej++;
        end else begin
          p = mb[m_src[5:3]][m_src[2:0]];
          if (p[2:0] == 3'd1 && sq[5:3] == (p[3] ? 3'd7 : 3'd0)) p = {p[3], 3'd5};
          m_capt = mb[sq[5:3]][sq[2:0]];
          mb[sq[5:3]][sq[2:0]] = p;
          mb[m_src[5:3]][m_src[2:0]] = 4'h0;
          m_lsrc = m_src;
          m_ldst = sq;
          if (m_capt[2:0] == 3'd6) m_go = 1'b1;
          m_turn = !m_turn;
          exp_bt++;
        end
      end
    end
  endtask

  // Pulse counting plus full comparison against the model once settled.
  always @(negedge clk) begin
    logic [255:0] a, e;
    if (live) begin
      if (begin_turn) bt_cnt++;
      if (move_reject) rej_cnt++;
      chk("move_done_vs_begin_turn", 256'(move_done), 256'(begin_turn));
      if (check_en) begin
        for (int r = 0; r < 8; r++)
          for (int c = 0; c < 8; c++) begin
            a[(r*8+c)*4 +: 4] = board[r][c];
            e[(r*8+c)*4 +: 4] = mb[r][c];
          end
        chk("board", a, e);
        chk("white_turn", 256'(white_turn), 256'(m_turn));
        chk("game_over", 256'(game_over), 256'(m_go));
        chk("last_src", 256'(last_src), 256'(m_lsrc));
        chk("last_dst", 256'(last_dst), 256'(m_ldst));
        chk("captured", 256'(captured), 256'(m_capt));
        chk("begin_turn_count", 256'(bt_cnt), 256'(exp_bt));
        chk("move_reject_count", 256'(rej_cnt), 256'(exp_rej));
      end
    end
  end

  task automatic step(input logic [5:0] mp, input logic pp, input logic [63:0] mask, input int hold);
    check_en = 1'b0;
    mouse_position = mp;
    pick_place = pp;
    possible_moves = mask;
    repeat (4) @(posedge clk);
    #1;
    if (pp && !pp_prev) model_pick(mp);
    else if (!pp && pp_prev) model_drop(mp, mask);
    pp_prev = pp;
    check_en = 1'b1;
    repeat (hold) @(posedge clk);
    #1;
  endtask

  task automatic move(input logic [5:0] s, input logic [5:0] d);
    step(s, 1'b1, 64'd0, 1);
    step(d, 1'b0, 64'd1 << d, 1);
  endtask

  task automatic do_reset(input bit hard);
    check_en = 1'b0;
    if (hard) rst = 1'b1;
    else new_game = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    new_game = 1'b0;
    model_init();
    check_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [127:0] mid;
    logic [5:0]   sq, d;
    logic [63:0]  mask;
    int           r;
    pp_prev = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    live = 1'b1;
    do_reset(1'b1);

    // Opening position pinned by literals.
    chk("init_b74", 256'(board[7][4]), 256'(4'h6));
    chk("init_b03", 256'(board[0][3]), 256'(4'hD));
    chk("init_b60", 256'(board[6][0]), 256'(4'h1));
    for (int i = 2; i < 6; i++)
      for (int c = 0; c < 8; c++)
        mid[((i-2)*8+c)*4 +: 4] = board[i][c];
    chk("init_mid_empty", 256'(mid), 256'd0);
    chk("init_white_turn", 256'(white_turn), 256'd1);

    // e2-e4 style pawn push.
    step(6'o64, 1'b1, 64'd0, 1);
    step(6'o44, 1'b0, 64'd1 << 36, 1);
    chk("push_b44", 256'(board[4][4]), 256'(4'h1));
    chk("push_b64", 256'(board[6][4]), 256'(4'h0));
    chk("push_turn", 256'(white_turn), 256'd0);
    chk("push_capt", 256'(captured), 256'd0);
    chk("push_bt_pulses", 256'(bt_cnt), 256'd1);

    // Black replies, then white tries to grab a black pawn.
    move(6'o13, 6'o33);
    step(6'o14, 1'b1, 64'd0, 1);
    step(6'o14, 1'b0, 64'd0, 1);
    chk("wrong_colour_rej", 256'(rej_cnt), 256'd1);

    // Put-back and illegal drop.
    step(6'o63, 1'b1, 64'd0, 1);
    step(6'o63, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    chk("putback_turn", 256'(white_turn), 256'd1);
    chk("putback_bt", 256'(bt_cnt), 256'd2);
    step(6'o63, 1'b1, 64'd0, 1);
    step(6'o43, 1'b0, ~(64'd1 << 35), 1);
    chk("illegal_rej", 256'(rej_cnt), 256'd2);
    chk("illegal_b63", 256'(board[6][3]), 256'(4'h1));

    // Promotion with rook capture.
    move(6'o60, 6'o10);
    move(6'o01, 6'o20);
    move(6'o61, 6'o51);
    move(6'o00, 6'o01);
    move(6'o10, 6'o01);
    chk("promo_b01", 256'(board[0][1]), 256'(4'h5));
    chk("promo_capt", 256'(captured), 256'(4'hC));

    // King capture ends the game; later picks are ignored.
    move(6'o16, 6'o36);
    move(6'o01, 6'o04);
    chk("king_capt", 256'(captured), 256'(4'hE));
    chk("game_over_set", 256'(game_over), 256'd1);
    step(6'o36, 1'b1, 64'd0, 1);
    step(6'o46, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    chk("go_no_rej", 256'(rej_cnt), 256'd2);
    chk("go_b36", 256'(board[3][6]), 256'(4'h9));

    // new_game while a piece is held discards it.
    do_reset(1'b0);
    step(6'o64, 1'b1, 64'd0, 1);
    do_reset(1'b0);
    step(6'o44, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    chk("ng_b64", 256'(board[6][4]), 256'(4'h1));
    chk("ng_b44", 256'(board[4][4]), 256'(4'h0));
    chk("ng_go", 256'(game_over), 256'd0);
    chk("ng_turn", 256'(white_turn), 256'd1);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      if ((m_go && $urandom_range(0, 1) == 0) || $urandom_range(0, 59) == 0)
        do_reset($urandom_range(0, 3) == 0);
      sq = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 3) != 0) begin
        for (int t = 0; t < 64; t++) begin
          if (mb[sq[5:3]][sq[2:0]] != 4'h0 && mb[sq[5:3]][sq[2:0]][3] == !m_turn) break;
          sq = 6'($urandom_range(0, 63));
        end
      end
      step(sq, 1'b1, {$urandom, $urandom}, 1 + $urandom_range(0, 2));
      if ($urandom_range(0, 2) == 0)
        step(6'($urandom_range(0, 63)), 1'b1, {$urandom, $urandom}, 1);
      d = 6'($urandom_range(0, 63));
      mask = {$urandom, $urandom};
      r = $urandom_range(0, 9);
      if (r < 6) mask[d] = 1'b1;
      else if (r < 8) mask[d] = 1'b0;
      else d = sq;
      step(d, 1'b0, mask, 1 + $urandom_range(0, 1));
    end

    check_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
